ff_bank: RTL and testbench

FF_BANK -- requirements
Module: ff_bank

---
 rtl/ff_bank_pkg.sv | 19 +
 rtl/ff_cell.sv | 77 +++++++
 rtl/ff_bank.sv | 65 ++++++
 tb/tb_ff_bank.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ff_bank_pkg.sv
// ff_bank_pkg: shared types for the configurable flip-flop bank.
//   mode_e      : per-cycle operating mode shared by every bit (SR, JK, D, T).
//   sr_policy_e : what an SR cell does when S and R are both high.
package ff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    SR_HOLD  = 2'b00,
    SR_SET   = 2'b01,
    SR_CLEAR = 2'b10
  } sr_policy_e;

endpackage

// File: rtl/ff_cell.sv
// ff_cell: one configurable flip-flop bit (SR/JK/D/T) with sticky SR-invalid flag.
// Latency: q and err_flag update on the rising edge after inputs; invalid is combinational.
// Backpressure: none; en=0 freezes the cell, rst (sync, active-high) dominates everything.
// Ports: clk, rst, en, mode, a (S/J/D/T), b (R/K), clr_err -> q, err_flag, invalid.
module ff_cell
  import ff_bank_pkg::*;
#(
  parameter logic       RESET_BIT  = 1'b0,
  parameter sr_policy_e SR_INVALID = SR_HOLD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       clr_err,
  output logic       q,
  output logic       err_flag,
  output logic       invalid
);

  mode_e m;
  logic  q_nxt;
  logic  sr_inv_val;

  assign m = mode_e'(mode);

  // Gated by en so the top-level counter only sees events that actually commit.
  assign invalid = en && (m == MODE_SR) && a && b;

  always_comb begin
    sr_inv_val = q;
    case (SR_INVALID)
      SR_SET:   sr_inv_val = 1'b1;
      SR_CLEAR: sr_inv_val = 1'b0;
      default:  sr_inv_val = q;
    endcase
  end

  always_comb begin
    q_nxt = q;
    case (m)
      MODE_SR: begin
        case ({a, b})
          2'b10:   q_nxt = 1'b1;
          2'b01:   q_nxt = 1'b0;
          2'b11:   q_nxt = sr_inv_val;
          default: q_nxt = q;
        endcase
      end
      MODE_JK: begin
        case ({a, b})
          2'b10:   q_nxt = 1'b1;
          2'b01:   q_nxt = 1'b0;
          2'b11:   q_nxt = ~q;
          default: q_nxt = q;
        endcase
      end
      MODE_D:  q_nxt = a;
      MODE_T:  q_nxt = a ? ~q : q;
      default: q_nxt = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= RESET_BIT;
      err_flag <= 1'b0;
    end else if (en) begin
      q <= q_nxt;
      // A same-cycle invalid event survives a clear.
      err_flag <= clr_err ? invalid : (err_flag | invalid);
    end
  end

endmodule

// File: rtl/ff_bank.sv
// ff_bank: WIDTH configurable flip-flops sharing mode/en, plus a saturating SR-invalid counter.
// Latency: one cycle from inputs to q/err_flags/err_cnt; qn is a combinational inverse of q.
// Backpressure: none; en=0 holds all state, synchronous active-high rst dominates.
// Ports: clk, rst, en, mode[1:0], a/b[WIDTH], clr_err -> q, qn, err_flags[WIDTH], err_cnt[CNT_W].
module ff_bank
  import ff_bank_pkg::*;
#(
  parameter int                     WIDTH      = 8,
  parameter logic [WIDTH-1:0]       RESET_VAL  = '0,
  parameter sr_policy_e             SR_INVALID = SR_HOLD,
  parameter int                     CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] err_flags,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] inv_vec;
  logic             any_inv;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .RESET_BIT  (RESET_VAL[i]),
      .SR_INVALID (SR_INVALID)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mode     (mode),
      .a        (a[i]),
      .b        (b[i]),
      .clr_err  (clr_err),
      .q        (q[i]),
      .err_flag (err_flags[i]),
      .invalid  (inv_vec[i])
    );
  end

  assign qn      = ~q;
  // One count per cycle, however many bits are invalid.
  assign any_inv = |inv_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (en) begin
      if (clr_err) begin
        err_cnt <= any_inv ? CNT_W'(1) : '0;
      end else if (any_inv && (err_cnt != CNT_MAX)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ff_bank.sv
// tb_ff_bank: scoreboard bench for ff_bank, WIDTH=4, RESET_VAL=1010, CNT_W=2,
// three instances sharing stimulus, one per SR-invalid policy (HOLD, SET, CLEAR).
module tb_ff_bank;
  import ff_bank_pkg::*;

  localparam int               W    = 4;
  localparam int               CW   = 2;
  localparam logic [W-1:0]     RV   = 4'b1010;
  localparam int               M_SR = 0, M_JK = 1, M_D = 2, M_T = 3;

  logic         clk = 1'b0;
  logic         rst, en, clr_err;
  logic [1:0]   mode;
  logic [W-1:0] a, b;

  logic [W-1:0]  q_h, qn_h, ef_h;  logic [CW-1:0] ec_h;
  logic [W-1:0]  q_s, qn_s, ef_s;  logic [CW-1:0] ec_s;
  logic [W-1:0]  q_c, qn_c, ef_c;  logic [CW-1:0] ec_c;

  always #5 clk = ~clk;

  ff_bank #(.WIDTH(W), .RESET_VAL(RV), .SR_INVALID(SR_HOLD), .CNT_W(CW)) u_hold (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
    .q(q_h), .qn(qn_h), .err_flags(ef_h), .err_cnt(ec_h));
  ff_bank #(.WIDTH(W), .RESET_VAL(RV), .SR_INVALID(SR_SET), .CNT_W(CW)) u_set (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
    .q(q_s), .qn(qn_s), .err_flags(ef_s), .err_cnt(ec_s));
  ff_bank #(.WIDTH(W), .RESET_VAL(RV), .SR_INVALID(SR_CLEAR), .CNT_W(CW)) u_clr (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
    .q(q_c), .qn(qn_c), .err_flags(ef_c), .err_cnt(ec_c));

  // Expected post-edge state for one stimulus cycle.
  typedef struct {
    int           id;
    logic [W-1:0] qh, qs, qc, ef;
    int           cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  // Reference state: q per policy (0=HOLD,1=SET,2=CLEAR), shared flags/count.
  logic [W-1:0] mq [3];
  logic [W-1:0] mef;
  int           mcnt;

  // Behaviour of one bit from the truth tables of each mode.
  function automatic logic next_bit(int md, int pol, logic qv, logic av, logic bv);
    if (md == M_D) return av;
    if (md == M_T) return av ? !qv : qv;
    if (av && !bv) return 1'b1;
    if (!av && bv) return 1'b0;
    if (!av && !bv) return qv;
    if (md == M_JK) return !qv;
    if (pol == 1) return 1'b1;
    if (pol == 2) return 1'b0;
    return qv;
  endfunction

  task automatic step(input logic r, input logic e, input int md,
                      input logic [W-1:0] av, input logic [W-1:0] bv, input logic c);
    exp_t         x;
    logic [W-1:0] inv;
    int           n_inv;
    @(negedge clk);
    rst = r; en = e; mode = md[1:0]; a = av; b = bv; clr_err = c;
    if (r) begin
      for (int p = 0; p < 3; p++) mq[p] = RV;
      mef  = '0;
      mcnt = 0;
    end else if (e) begin
      for (int p = 0; p < 3; p++)
        for (int i = 0; i < W; i++)
          mq[p][i] = next_bit(md, p, mq[p][i], av[i], bv[i]);
      inv   = (md == M_SR) ? (av & bv) : '0;
      n_inv = (inv != 0) ? 1 : 0;
      if (c) begin
        mef  = inv;
        mcnt = n_inv;
      end else begin
        mef  = mef | inv;
        mcnt = (mcnt + n_inv > 3) ? 3 : mcnt + n_inv;
      end
    end
    x.id = step_id; x.qh = mq[0]; x.qs = mq[1]; x.qc = mq[2]; x.ef = mef; x.cnt = mcnt;
    sb.push_back(x);
    step_id++;
  endtask

  task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: got %b, expected %b", name, id, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare after each edge that has stimulus.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("q_hold",   e.id, {4'b0, q_h},  {4'b0, e.qh});
      chk("q_set",    e.id, {4'b0, q_s},  {4'b0, e.qs});
      chk("q_clear",  e.id, {4'b0, q_c},  {4'b0, e.qc});
      chk("qn_hold",  e.id, {4'b0, qn_h}, {4'b0, ~e.qh});
      chk("qn_set",   e.id, {4'b0, qn_s}, {4'b0, ~e.qs});
      chk("qn_clear", e.id, {4'b0, qn_c}, {4'b0, ~e.qc});
      chk("err_flags_hold", e.id, {4'b0, ef_h}, {4'b0, e.ef});
      chk("err_flags_set",  e.id, {4'b0, ef_s}, {4'b0, e.ef});
      chk("err_flags_clr",  e.id, {4'b0, ef_c}, {4'b0, e.ef});
      chk("err_cnt_hold", e.id, {6'b0, ec_h}, 8'(e.cnt));
      chk("err_cnt_set",  e.id, {6'b0, ec_s}, 8'(e.cnt));
      chk("err_cnt_clr",  e.id, {6'b0, ec_c}, 8'(e.cnt));
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; a = '0; b = '0; clr_err = 1'b0;
    for (int p = 0; p < 3; p++) mq[p] = RV;
    mef = '0; mcnt = 0;

    // Reset state.
    step(1, 0, M_SR, 4'b0000, 4'b0000, 0);
    // SR set/clear, then invalid on bit 2.
    step(0, 1, M_SR, 4'b0001, 4'b0010, 0);
    step(0, 1, M_SR, 4'b0100, 4'b0100, 0);
    // JK toggle from 0000, flags must persist.
    step(0, 1, M_D,  4'b0000, 4'b0000, 0);
    for (int k = 0; k < 3; k++) step(0, 1, M_JK, 4'b1111, 4'b1111, 0);
    // T mode with en 1,0,1.
    step(0, 1, M_D, 4'b0000, 4'b0000, 0);
    step(0, 1, M_T, 4'b0011, 4'b0000, 0);
    step(0, 0, M_T, 4'b0011, 4'b0000, 0);
    step(0, 1, M_T, 4'b0011, 4'b0000, 0);
    // Counter saturation, clear with coincident event, plain clear, clear while disabled.
    step(1, 0, M_SR, 4'b0000, 4'b0000, 0);
    for (int k = 0; k < 5; k++) step(0, 1, M_SR, 4'b0001, 4'b0001, 0);
    step(0, 1, M_SR, 4'b0011, 4'b0011, 1);
    step(0, 0, M_SR, 4'b0000, 4'b0000, 1);
    step(0, 1, M_SR, 4'b0000, 4'b0000, 1);
    // Reset dominates enable and data; then resumes.
    step(1, 1, M_D, 4'b0110, 4'b0000, 0);
    step(0, 1, M_D, 4'b0110, 4'b0000, 0);
    // Reset asserted mid-sequence with invalid inputs and clr_err.
    step(0, 1, M_SR, 4'b1111, 4'b1111, 0);
    step(1, 1, M_SR, 4'b1111, 4'b1111, 1);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 3),
           4'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0));
    end

    // Drain the scoreboard with a bounded wait.
    for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
